sram_port_arbiter: RTL and testbench

- Shares the single-port grid SRAM between two requesters.
  - Port 0: maze_router core.
  - Port 1: host grid loader / result readback unit.
- Sits between the requesters and sram; drives the sram clk/address/data_in/cs/we pins.
- Round-robin arbitration with an optional lock for atomic read-modify-write and bursts.
- Returns read data tagged to the issuing port.

---
 rtl/sram_arb_pkg.sv | 17 +
 rtl/sram_rd_tag_pipe.sv | 43 ++++
 rtl/sram_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the grid SRAM port arbiter: FSM encoding, read tag and default widths.
package sram_arb_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_ADDR_WIDTH = 8;
    localparam int unsigned DEF_RD_LAT     = 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOCK0 = 2'd1;
    localparam logic [1:0] LOCK1 = 2'd2;

    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

endpackage

// File: rtl/sram_rd_tag_pipe.sv
// Shift register of {valid, port} tags that follows each read through the SRAM latency
// and raises rvalid for the issuing port when its data appears on data_in.
module sram_rd_tag_pipe
    import sram_arb_pkg::*;
#(
    parameter int unsigned RD_LAT = DEF_RD_LAT
) (
    input  logic clk,
    input  logic reset,
    input  logic issue_read,
    input  logic issue_port,
    output logic rvalid0,
    output logic rvalid1,
    output logic busy
);

    // Stage 0 lines up with the cs cycle; the last stage lines up with valid read data.
    localparam int unsigned DEPTH = RD_LAT + 1;

    rd_tag_t [DEPTH-1:0] tag_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= '{valid: issue_read, port: issue_port};
            for (int unsigned i = 1; i < DEPTH; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign rvalid0 = tag_q[DEPTH-1].valid & ~tag_q[DEPTH-1].port;
    assign rvalid1 = tag_q[DEPTH-1].valid &  tag_q[DEPTH-1].port;

    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            busy = busy | tag_q[i].valid;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter in front of the single-port grid SRAM, with an ownership
// lock for read-modify-write and bursts, and per-port tagged read return.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned RD_LAT     = DEF_RD_LAT
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  r0_req,
    input  logic                  r0_we,
    input  logic                  r0_lock,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_gnt,
    output logic                  r0_rvalid,
    output logic [DATA_WIDTH-1:0] r0_rdata,

    input  logic                  r1_req,
    input  logic                  r1_we,
    input  logic                  r1_lock,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_gnt,
    output logic                  r1_rvalid,
    output logic [DATA_WIDTH-1:0] r1_rdata,

    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  cs,
    output logic                  we,
    output logic                  busy
);

    logic [1:0]            state_q, state_d;
    logic                  last_winner_q, last_winner_d;
    logic                  gnt0, gnt1, any_gnt;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  cs_q, we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  rvalid0, rvalid1, tag_busy;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // On a tie the port that did not win last time goes first.
                if (r0_req && (!r1_req || last_winner_q)) begin
                    gnt0 = 1'b1;
                end else if (r1_req) begin
                    gnt1 = 1'b1;
                end
                if (gnt0 && r0_lock) begin
                    state_d = LOCK0;
                end else if (gnt1 && r1_lock) begin
                    state_d = LOCK1;
                end
            end
            LOCK0: begin
                gnt0 = r0_req;
                if (!r0_lock) state_d = IDLE;
            end
            LOCK1: begin
                gnt1 = r1_req;
                if (!r1_lock) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign any_gnt       = gnt0 | gnt1;
    assign last_winner_d = gnt1 ? 1'b1 : (gnt0 ? 1'b0 : last_winner_q);
    assign sel_we        = gnt1 ? r1_we    : r0_we;
    assign sel_addr      = gnt1 ? r1_addr  : r0_addr;
    assign sel_wdata     = gnt1 ? r1_wdata : r0_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            last_winner_q <= 1'b1;
            cs_q          <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            last_winner_q <= last_winner_d;
            cs_q          <= any_gnt;
            we_q          <= any_gnt & sel_we;
            if (any_gnt) begin
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
        end
    end

    sram_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk        (clk),
        .reset      (reset),
        .issue_read (any_gnt & ~sel_we),
        .issue_port (gnt1),
        .rvalid0    (rvalid0),
        .rvalid1    (rvalid1),
        .busy       (tag_busy)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (rvalid0) rdata0_q <= data_in;
            if (rvalid1) rdata1_q <= data_in;
        end
    end

    // SRAM data is only valid during the rvalid cycle, so pass it through then and hold after.
    assign r0_rdata  = rvalid0 ? data_in : rdata0_q;
    assign r1_rdata  = rvalid1 ? data_in : rdata1_q;
    assign r0_rvalid = rvalid0;
    assign r1_rvalid = rvalid1;
    assign r0_gnt    = gnt0;
    assign r1_gnt    = gnt1;

    assign address  = addr_q;
    assign data_out = wdata_q;
    assign cs       = cs_q;
    assign we       = we_q;
    assign busy     = cs_q | tag_busy;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: one RD_LAT=1 instance driven from a vector table and
// hand sequences, plus an RD_LAT=3 instance for the long-latency read.
module tb_sram_port_arbiter;

    logic       clk;
    logic       reset;

    logic       r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
    logic [7:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic       r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [7:0] r0_rdata, r1_rdata;
    logic [7:0] address, data_out, data_in;
    logic       cs, we, busy;

    logic       l_r0_req, l_r1_req;
    logic [7:0] l_r0_addr;
    logic       l_r0_gnt, l_r0_rvalid, l_r1_gnt, l_r1_rvalid;
    logic [7:0] l_r0_rdata, l_r1_rdata;
    logic [7:0] l_address, l_data_out, l_data_in;
    logic       l_cs, l_we, l_busy;

    int n_checks = 0;
    int n_fail   = 0;

    sram_port_arbiter #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (8),
        .RD_LAT     (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .r0_req    (r0_req),
        .r0_we     (r0_we),
        .r0_lock   (r0_lock),
        .r0_addr   (r0_addr),
        .r0_wdata  (r0_wdata),
        .r0_gnt    (r0_gnt),
        .r0_rvalid (r0_rvalid),
        .r0_rdata  (r0_rdata),
        .r1_req    (r1_req),
        .r1_we     (r1_we),
        .r1_lock   (r1_lock),
        .r1_addr   (r1_addr),
        .r1_wdata  (r1_wdata),
        .r1_gnt    (r1_gnt),
        .r1_rvalid (r1_rvalid),
        .r1_rdata  (r1_rdata),
        .address   (address),
        .data_out  (data_out),
        .data_in   (data_in),
        .cs        (cs),
        .we        (we),
        .busy      (busy)
    );

    sram_port_arbiter #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (8),
        .RD_LAT     (3)
    ) dut3 (
        .clk       (clk),
        .reset     (reset),
        .r0_req    (l_r0_req),
        .r0_we     (1'b0),
        .r0_lock   (1'b0),
        .r0_addr   (l_r0_addr),
        .r0_wdata  (8'h00),
        .r0_gnt    (l_r0_gnt),
        .r0_rvalid (l_r0_rvalid),
        .r0_rdata  (l_r0_rdata),
        .r1_req    (l_r1_req),
        .r1_we     (1'b0),
        .r1_lock   (1'b0),
        .r1_addr   (8'h00),
        .r1_wdata  (8'h00),
        .r1_gnt    (l_r1_gnt),
        .r1_rvalid (l_r1_rvalid),
        .r1_rdata  (l_r1_rdata),
        .address   (l_address),
        .data_out  (l_data_out),
        .data_in   (l_data_in),
        .cs        (l_cs),
        .we        (l_we),
        .busy      (l_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM models: unwritten words read as addr ^ 8'h5A; the RD_LAT=3 part holds 8'h7F at 8'h40.
    logic [7:0]   mem1 [256];
    logic [255:0] wr1 = '0;
    logic [7:0]   pipe1;
    logic [7:0]   pipe3 [3];

    always @(posedge clk) begin
        if (cs && we) begin
            mem1[address] <= data_out;
            wr1[address]  <= 1'b1;
        end
        pipe1 <= wr1[address] ? mem1[address] : (address ^ 8'h5A);
    end
    assign data_in = pipe1;

    always @(posedge clk) begin
        pipe3[0] <= (l_address == 8'h40) ? 8'h7F : 8'h00;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign l_data_in = pipe3[2];

    task automatic check1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       q0, we0, lk0;
        logic [7:0] a0, d0;
        logic       q1, lk1;
        logic [7:0] a1;
        logic       g0, g1, cs, we;
        logic [7:0] addr, wd;
        logic       rv0, rv1;
        logic [7:0] rd;
    } vec_t;

    function automatic vec_t v(
        input logic rst, input logic q0, input logic we0, input logic lk0,
        input logic [7:0] a0, input logic [7:0] d0,
        input logic q1, input logic lk1, input logic [7:0] a1,
        input logic g0, input logic g1, input logic e_cs, input logic e_we,
        input logic [7:0] addr, input logic [7:0] wd,
        input logic rv0, input logic rv1, input logic [7:0] rd);
        vec_t t;
        t.rst = rst; t.q0 = q0; t.we0 = we0; t.lk0 = lk0; t.a0 = a0; t.d0 = d0;
        t.q1 = q1; t.lk1 = lk1; t.a1 = a1;
        t.g0 = g0; t.g1 = g1; t.cs = e_cs; t.we = e_we; t.addr = addr; t.wd = wd;
        t.rv0 = rv0; t.rv1 = rv1; t.rd = rd;
        return t;
    endfunction

    vec_t vecs[$];

    task automatic clear_inputs();
        r0_req = 0; r0_we = 0; r0_lock = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_we = 0; r1_lock = 0; r1_addr = 0; r1_wdata = 0;
    endtask

    initial begin
        //             rst q0 we lk a0     d0     q1 lk a1     g0 g1 cs we addr   wd     rv0 rv1 rd
        // Port 0 only: write then read back
        vecs.push_back(v(0, 1, 1, 0, 8'h10, 8'hA5, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00));
        vecs.push_back(v(0, 1, 0, 0, 8'h10, 8'h00, 0, 0, 8'h00, 1, 0, 1, 1, 8'h10, 8'hA5, 0, 0, 8'h00));
        vecs.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00));
        vecs.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'hA5));
        vecs.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00));
        // Both request every cycle from reset: alternate r0, r1
        vecs.push_back(v(1, 1, 0, 0, 8'h01, 8'h00, 1, 0, 8'h02, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00));
        vecs.push_back(v(0, 1, 0, 0, 8'h01, 8'h00, 1, 0, 8'h02, 0, 1, 1, 0, 8'h01, 8'h00, 0, 0, 8'h00));
        vecs.push_back(v(0, 1, 0, 0, 8'h01, 8'h00, 1, 0, 8'h02, 1, 0, 1, 0, 8'h02, 8'h00, 1, 0, 8'h5B));
        vecs.push_back(v(0, 1, 0, 0, 8'h01, 8'h00, 1, 0, 8'h02, 0, 1, 1, 0, 8'h01, 8'h00, 0, 1, 8'h58));
        vecs.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 8'h02, 8'h00, 1, 0, 8'h5B));
        vecs.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 8'h58));
        vecs.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00));
        // r1 locked burst 20..23, release on 24, r0 waiting throughout
        vecs.push_back(v(0, 1, 0, 0, 8'h05, 8'h00, 1, 1, 8'h20, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00));
        vecs.push_back(v(0, 1, 0, 0, 8'h05, 8'h00, 1, 1, 8'h20, 0, 1, 1, 0, 8'h05, 8'h00, 0, 0, 8'h00));
        vecs.push_back(v(0, 1, 0, 0, 8'h05, 8'h00, 1, 1, 8'h21, 0, 1, 1, 0, 8'h20, 8'h00, 1, 0, 8'h5F));
        vecs.push_back(v(0, 1, 0, 0, 8'h05, 8'h00, 1, 1, 8'h22, 0, 1, 1, 0, 8'h21, 8'h00, 0, 1, 8'h7A));
        vecs.push_back(v(0, 1, 0, 0, 8'h05, 8'h00, 1, 1, 8'h23, 0, 1, 1, 0, 8'h22, 8'h00, 0, 1, 8'h7B));
        vecs.push_back(v(0, 1, 0, 0, 8'h05, 8'h00, 1, 0, 8'h24, 0, 1, 1, 0, 8'h23, 8'h00, 0, 1, 8'h78));
        vecs.push_back(v(0, 1, 0, 0, 8'h05, 8'h00, 0, 0, 8'h00, 1, 0, 1, 0, 8'h24, 8'h00, 0, 1, 8'h79));
        vecs.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 8'h05, 8'h00, 0, 1, 8'h7E));
        vecs.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h5F));
        // Locked owner idles for three cycles, then drops lock
        vecs.push_back(v(0, 1, 0, 0, 8'h06, 8'h00, 1, 1, 8'h30, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00));
        vecs.push_back(v(0, 1, 0, 0, 8'h06, 8'h00, 0, 1, 8'h00, 0, 0, 1, 0, 8'h30, 8'h00, 0, 0, 8'h00));
        vecs.push_back(v(0, 1, 0, 0, 8'h06, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 8'h6A));
        vecs.push_back(v(0, 1, 0, 0, 8'h06, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00));
        vecs.push_back(v(0, 1, 0, 0, 8'h06, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00));
        vecs.push_back(v(0, 1, 0, 0, 8'h06, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00));
        vecs.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 8'h06, 8'h00, 0, 0, 8'h00));
        vecs.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h5C));

        clear_inputs();
        l_r0_req = 0; l_r1_req = 0; l_r0_addr = 0;
        reset = 1'b0;
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check1("reset cs", cs, 1'b0);
        check1("reset we", we, 1'b0);
        check1("reset busy", busy, 1'b0);
        check1("reset r0_rvalid", r0_rvalid, 1'b0);
        check1("reset r1_rvalid", r1_rvalid, 1'b0);
        check8("reset address", address, 8'h00);
        check8("reset data_out", data_out, 8'h00);
        check1("reset lat3 busy", l_busy, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].rst) begin
                clear_inputs();
                reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
            end
            r0_req = vecs[i].q0; r0_we = vecs[i].we0; r0_lock = vecs[i].lk0;
            r0_addr = vecs[i].a0; r0_wdata = vecs[i].d0;
            r1_req = vecs[i].q1; r1_we = 1'b0; r1_lock = vecs[i].lk1;
            r1_addr = vecs[i].a1; r1_wdata = 8'h00;
            @(negedge clk);
            check1($sformatf("v%0d r0_gnt", i), r0_gnt, vecs[i].g0);
            check1($sformatf("v%0d r1_gnt", i), r1_gnt, vecs[i].g1);
            check1($sformatf("v%0d cs", i), cs, vecs[i].cs);
            check1($sformatf("v%0d we", i), we, vecs[i].we);
            if (vecs[i].cs) check8($sformatf("v%0d address", i), address, vecs[i].addr);
            if (vecs[i].we) check8($sformatf("v%0d data_out", i), data_out, vecs[i].wd);
            check1($sformatf("v%0d r0_rvalid", i), r0_rvalid, vecs[i].rv0);
            check1($sformatf("v%0d r1_rvalid", i), r1_rvalid, vecs[i].rv1);
            if (vecs[i].rv0) check8($sformatf("v%0d r0_rdata", i), r0_rdata, vecs[i].rd);
            if (vecs[i].rv1) check8($sformatf("v%0d r1_rdata", i), r1_rdata, vecs[i].rd);
            @(posedge clk);
            #1;
        end

        // Reset with two reads in flight: last winner is r0, so r1 goes first
        clear_inputs();
        r0_req = 1; r0_addr = 8'h01; r1_req = 1; r1_addr = 8'h02;
        @(negedge clk);
        check1("inflight r1_gnt", r1_gnt, 1'b1);
        @(posedge clk);
        #1 r1_req = 0;
        @(negedge clk);
        check1("inflight r0_gnt", r0_gnt, 1'b1);
        @(posedge clk);
        #1 r0_req = 0;
        #2;
        check1("pre-reset r1_rvalid", r1_rvalid, 1'b1);
        reset = 1'b1;
        #1;
        check1("async cs", cs, 1'b0);
        check1("async we", we, 1'b0);
        check1("async busy", busy, 1'b0);
        check8("async address", address, 8'h00);
        check8("async data_out", data_out, 8'h00);
        check1("async r0_rvalid", r0_rvalid, 1'b0);
        check1("async r1_rvalid", r1_rvalid, 1'b0);
        check8("async r0_rdata", r0_rdata, 8'h00);
        check8("async r1_rdata", r1_rdata, 8'h00);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            check1($sformatf("dropped r0_rvalid %0d", k), r0_rvalid, 1'b0);
            check1($sformatf("dropped r1_rvalid %0d", k), r1_rvalid, 1'b0);
        end
        @(posedge clk);
        #1;
        r0_req = 1; r0_addr = 8'h03; r1_req = 1; r1_addr = 8'h04;
        @(negedge clk);
        check1("post-reset tie r0_gnt", r0_gnt, 1'b1);
        check1("post-reset tie r1_gnt", r1_gnt, 1'b0);
        @(posedge clk);
        #1 clear_inputs();

        // RD_LAT=3 instance: rvalid four cycles after grant, busy through the rvalid cycle
        l_r0_req = 1; l_r0_addr = 8'h40;
        @(negedge clk);
        check1("lat3 gnt", l_r0_gnt, 1'b1);
        check1("lat3 busy at gnt", l_busy, 1'b0);
        @(posedge clk);
        #1 l_r0_req = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check1($sformatf("lat3 busy +%0d", k), l_busy, (k <= 4));
            check1($sformatf("lat3 r0_rvalid +%0d", k), l_r0_rvalid, (k == 4));
            check1($sformatf("lat3 r1_rvalid +%0d", k), l_r1_rvalid, 1'b0);
            if (k == 4) check8("lat3 r0_rdata", l_r0_rdata, 8'h7F);
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
